// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for one 2-input gate.
// Drives {A,B} through 00, 01, 10, 11. Each vector is held SETTLE_CYCLES+1 cycles,
// then Y is checked against the truth table chosen by gate_sel.
// Optional feature: define GATE_SWEEP_ERRLOG_EN to add first-failure logging outputs.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
`ifdef GATE_SWEEP_ERRLOG_EN
    ,
    output logic       first_fail_vld,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_y
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] SETTLE = SETTLE_CYCLES[7:0];

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] tt_q, tt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       mismatch;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic       ff_vld_q, ff_vld_d;
    logic [1:0] ff_vec_q, ff_vec_d;
    logic       ff_y_q, ff_y_d;
`endif

    // Expected Y for each vector, bit index = {A,B}; 6 and 7 have no table
    function automatic logic [3:0] truth_table(input logic [2:0] sel);
        case (sel)
            3'd0:    truth_table = 4'b1000;
            3'd1:    truth_table = 4'b0111;
            3'd2:    truth_table = 4'b1110;
            3'd3:    truth_table = 4'b0001;
            3'd4:    truth_table = 4'b0110;
            3'd5:    truth_table = 4'b1001;
            default: truth_table = 4'b0000;
        endcase
    endfunction

    // Next-state and result logic: settle counting, sampling and vector stepping
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        tt_d        = tt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        mismatch    = 1'b0;
`ifdef GATE_SWEEP_ERRLOG_EN
        ff_vld_d    = ff_vld_q;
        ff_vec_d    = ff_vec_q;
        ff_y_d      = ff_y_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (gate_sel <= 3'd5) begin
                        tt_d        = truth_table(gate_sel);
                        pass_d      = 1'b0;
                        fail_mask_d = 4'b0000;
                        vec_d       = 2'd0;
                        cnt_d       = 8'd0;
                        busy_d      = 1'b1;
                        state_d     = RUN;
`ifdef GATE_SWEEP_ERRLOG_EN
                        ff_vld_d    = 1'b0;
                        ff_vec_d    = 2'd0;
                        ff_y_d      = 1'b0;
`endif
                    end else begin
                        done_d      = 1'b1;
                        pass_d      = 1'b0;
                        fail_mask_d = 4'b1111;
`ifdef GATE_SWEEP_ERRLOG_EN
                        ff_vld_d    = 1'b1;
                        ff_vec_d    = 2'd0;
                        ff_y_d      = 1'b0;
`endif
                    end
                end
            end
            RUN: begin
                if (cnt_q != SETTLE) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    mismatch            = (Y != tt_q[vec_q]);
                    fail_mask_d[vec_q]  = fail_mask_q[vec_q] | mismatch;
`ifdef GATE_SWEEP_ERRLOG_EN
                    if (mismatch && !ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = vec_q;
                        ff_y_d   = Y;
                    end
`endif
                    if (vec_q != 2'd3) begin
                        vec_d = vec_q + 2'd1;
                        cnt_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_mask_d == 4'b0000);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any sweep without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 8'd0;
            tt_q        <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'b0000;
`ifdef GATE_SWEEP_ERRLOG_EN
            ff_vld_q    <= 1'b0;
            ff_vec_q    <= 2'd0;
            ff_y_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            tt_q        <= tt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
`ifdef GATE_SWEEP_ERRLOG_EN
            ff_vld_q    <= ff_vld_d;
            ff_vec_q    <= ff_vec_d;
            ff_y_q      <= ff_y_d;
`endif
        end
    end

    assign A         = vec_q[1];
    assign B         = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
`ifdef GATE_SWEEP_ERRLOG_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_y   = ff_y_q;
`endif

endmodule
